// File: rtl/shiftreg_univ_pkg.sv
// shiftreg_univ_pkg: mode encodings and the width helper shared by the shift register files.
package shiftreg_univ_pkg;

    typedef enum logic [1:0] {
        SR_HOLD = 2'b00,
        SR_SHR  = 2'b01,
        SR_SHL  = 2'b10,
        SR_LOAD = 2'b11
    } sr_mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/shiftreg_univ_if.sv
// shiftreg_univ_if: control, data and status bundle of the universal shift register.
interface shiftreg_univ_if
    import shiftreg_univ_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int FW = clog2(DEPTH + 1);

    logic                   en;
    logic                   clr;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       sin_r;
    logic [WIDTH-1:0]       sin_l;
    logic [WIDTH*DEPTH-1:0] pin;
    logic [WIDTH*DEPTH-1:0] pout;
    logic [WIDTH-1:0]       sout_r;
    logic [WIDTH-1:0]       sout_l;
    logic [FW-1:0]          fill;
    logic                   full;

    modport master (
        output en, clr, mode, sin_r, sin_l, pin,
        input  pout, sout_r, sout_l, fill, full
    );

    modport slave (
        input  en, clr, mode, sin_r, sin_l, pin,
        output pout, sout_r, sout_l, fill, full
    );
endinterface

// File: rtl/shiftreg_univ_stage.sv
// shiftreg_stage: one WIDTH-bit stage with async reset, sync clear and load enable.
module shiftreg_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        data_q <= '0;
        else if (clr_i) data_q <= '0;
        else if (en_i)  data_q <= d_i;
    end

    assign q_o = data_q;
endmodule

// File: rtl/shiftreg_univ.sv
// shiftreg_univ: DEPTH x WIDTH universal shift register with hold/shift/load, optional rotate
// and a saturating fill counter.
module shiftreg_univ
    import shiftreg_univ_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter bit ROTATE = 1'b0
) (
    input logic           clk,
    input logic           rst,
    shiftreg_univ_if.slave sr
);
    localparam int FW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] stg_q [DEPTH];
    logic [FW-1:0]    fill_q, fill_d;
    logic             shr, shl, load, upd, full;

    assign shr  = sr.en && (sr.mode == SR_SHR);
    assign shl  = sr.en && (sr.mode == SR_SHL);
    assign load = sr.en && (sr.mode == SR_LOAD);
    assign upd  = shr || shl || load;
    assign full = (fill_q == FW'(DEPTH));

    for (genvar g = 0; g < DEPTH; g++) begin : g_stg
        logic [WIDTH-1:0] r_in, l_in;
        // End stages take the serial input, or the opposite end stage when rotating.
        if (g == 0) begin : g_r_end
            assign r_in = ROTATE ? stg_q[DEPTH-1] : sr.sin_r;
        end else begin : g_r_mid
            assign r_in = stg_q[g-1];
        end
        if (g == DEPTH - 1) begin : g_l_end
            assign l_in = ROTATE ? stg_q[0] : sr.sin_l;
        end else begin : g_l_mid
            assign l_in = stg_q[g+1];
        end
        shiftreg_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clr_i (sr.clr),
            .en_i  (upd),
            .d_i   (load ? sr.pin[g*WIDTH +: WIDTH] : shr ? r_in : l_in),
            .q_o   (stg_q[g])
        );
    end

    always_comb begin
        sr.pout = '0;
        for (int i = 0; i < DEPTH; i++) sr.pout[i*WIDTH +: WIDTH] = stg_q[i];
    end

    // Rotation only recirculates existing data, so it never adds to the fill count.
    always_comb begin
        fill_d = load ? FW'(DEPTH)
               : ((shr || shl) && !ROTATE && !full) ? fill_q + 1'b1
               : fill_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         fill_q <= '0;
        else if (sr.clr) fill_q <= '0;
        else             fill_q <= fill_d;
    end

    assign sr.sout_r = stg_q[DEPTH-1];
    assign sr.sout_l = stg_q[0];
    assign sr.fill   = fill_q;
    assign sr.full   = full;
endmodule

// File: tb/tb_shiftreg_univ.sv
// tb_shiftreg_univ: directed vectors for shiftreg_univ, plain and rotating 4x4 instances.
module tb_shiftreg_univ;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vec = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    shiftreg_univ_if #(.WIDTH(4), .DEPTH(4)) a ();
    shiftreg_univ_if #(.WIDTH(4), .DEPTH(4)) b ();

    shiftreg_univ #(.WIDTH(4), .DEPTH(4), .ROTATE(1'b0)) u0 (.clk(clk), .rst(rst), .sr(a));
    shiftreg_univ #(.WIDTH(4), .DEPTH(4), .ROTATE(1'b1)) u1 (.clk(clk), .rst(rst), .sr(b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {a.en, a.clr, a.mode, a.sin_r, a.sin_l, a.pin} = '0;
        {b.en, b.clr, b.mode, b.sin_r, b.sin_l, b.pin} = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_pout", a.pout, 32'h0);
        chk("rst_fill", a.fill, 32'd0);
        chk("rst_full", a.full, 32'd0);
        #1 rst = 1'b0;
        // right shifts from empty, including saturation past DEPTH
        a.en = 1'b1; a.mode = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            a.sin_r = 4'(i);
            tick();
            chk($sformatf("shr_fill%0d", i), a.fill, 32'(i));
            chk($sformatf("shr_full%0d", i), a.full, (i == 4) ? 32'd1 : 32'd0);
        end
        chk("shr_pout", a.pout, 32'h1234);
        chk("shr_sout_r", a.sout_r, 32'h1);
        chk("shr_sout_l", a.sout_l, 32'h4);
        a.sin_r = 4'h5; tick();
        chk("sat_fill5", a.fill, 32'd4);
        a.sin_r = 4'h6; tick();
        chk("sat_fill6", a.fill, 32'd4);
        chk("sat_full", a.full, 32'd1);
        chk("sat_pout", a.pout, 32'h3456);
        // parallel load then left shift
        a.mode = 2'b11; a.pin = 16'hABCD; tick();
        chk("load_pout", a.pout, 32'hABCD);
        a.mode = 2'b10; a.sin_l = 4'hE; tick();
        chk("shl_pout", a.pout, 32'hEABC);
        chk("shl_sout_l", a.sout_l, 32'hC);
        chk("shl_sout_r", a.sout_r, 32'hE);
        chk("shl_fill", a.fill, 32'd4);
        // clear overrides an enabled load
        a.mode = 2'b11; a.pin = 16'h1234; tick();
        chk("load2_pout", a.pout, 32'h1234);
        a.clr = 1'b1; a.pin = 16'hFFFF; tick();
        chk("clr_pout", a.pout, 32'h0);
        chk("clr_fill", a.fill, 32'd0);
        a.clr = 1'b0; a.en = 1'b0; a.mode = 2'b01; a.sin_r = 4'h7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold0_pout", a.pout, 32'h0);
            chk("hold0_fill", a.fill, 32'd0);
        end
        a.en = 1'b1; a.mode = 2'b11; a.pin = 16'h1234; tick();
        a.en = 1'b0; a.mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pout", a.pout, 32'h1234);
            chk("hold_fill", a.fill, 32'd4);
        end
        // asynchronous reset between edges
        rst = 1'b1;
        #2;
        chk("arst_pout", a.pout, 32'h0);
        chk("arst_fill", a.fill, 32'd0);
        chk("arst_full", a.full, 32'd0);
        rst = 1'b0;
        a.en = 1'b1; a.mode = 2'b01; a.sin_r = 4'h5; tick();
        chk("post_rst_pout", a.pout, 32'h0005);
        chk("post_rst_fill", a.fill, 32'd1);
        // rotating instance: shifts recirculate and leave fill alone
        b.en = 1'b1; b.mode = 2'b01; b.sin_r = 4'hF; tick();
        chk("rot_empty_fill", b.fill, 32'd0);
        b.mode = 2'b11; b.pin = 16'h1234; tick();
        chk("rot_load_fill", b.fill, 32'd4);
        b.mode = 2'b01; tick();
        chk("rot_shr_pout", b.pout, 32'h2341);
        chk("rot_shr_fill", b.fill, 32'd4);
        b.mode = 2'b10; b.sin_l = 4'hF; tick();
        chk("rot_shl_pout", b.pout, 32'h1234);
        chk("rot_shl_fill", b.fill, 32'd4);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
